// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

  // md_op encodings. Bit 1 selects divide; bit 0 selects unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Radix-2 steps per operation.
  localparam int MD_ITER = 32;
  localparam int CNT_W   = $clog2(MD_ITER);

  // Operation context captured at launch and used again at sign fix-up.
  typedef struct packed {
    md_op_e op;
    logic   sign_a;
    logic   sign_b;
  } md_ctx_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {accumulator, low operand}.
// Multiply: right-shifting shift-add. The low half holds the remaining multiplier bits.
// Divide: restoring shift-subtract. The low half shifts out dividend bits and shifts in quotient bits.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  output logic [2*W-1:0] acc_next,
  output logic           q_bit
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic [W:0] upper;

  // Both step flavours use W+1-bit adders.
  // The remainder stays below the divisor, so diff[W] is exactly the borrow of the trial subtract.
  always_comb begin
    upper    = acc[2*W-1:W-1];
    sum      = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
    diff     = upper - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = acc;
    if (is_div) begin
      q_bit    = ~diff[W];
      acc_next = {(q_bit ? diff[W-1:0] : upper[W-1:0]), acc[W-2:0], q_bit};
    end else if (acc[0]) begin
      acc_next = {sum, acc[W-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*W-1:W], acc[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// Each operation takes 33 cycles: 32 radix-2 steps, then one sign-fix cycle.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int MD_W = 32
) (
  input  logic            clk,
  input  logic            rst_md,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [MD_W-1:0] md_src_a,
  input  logic [MD_W-1:0] md_src_b,
  input  logic            md_hi_write,
  input  logic            md_lo_write,
  output logic            md_busy,
  output logic            md_done,
  output logic [MD_W-1:0] md_hi,
  output logic [MD_W-1:0] md_lo
);

  md_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt;
  md_ctx_t           ctx;
  logic [MD_W-1:0]   a_raw;   // dividend as issued; the divide-by-zero HI value
  logic [MD_W-1:0]   opnd;    // |multiplicand| or |divisor|
  logic [2*MD_W-1:0] acc;
  logic [2*MD_W-1:0] acc_step;
  logic              q_unused;
  logic [MD_W-1:0]   hi, lo;
  logic              done;

  logic              in_sgn;
  logic [MD_W-1:0]   abs_a, abs_b;
  logic [MD_W-1:0]   res_hi, res_lo;
  logic [2*MD_W-1:0] prod;
  logic [MD_W-1:0]   quo, rem;

  assign md_hi   = hi;
  assign md_lo   = lo;
  assign md_done = done;

  // Absolute operands at launch; only the signed ops are folded.
  always_comb begin
    in_sgn = ~md_op[0];
    abs_a  = (in_sgn && md_src_a[MD_W-1]) ? (~md_src_a + 1'b1) : md_src_a;
    abs_b  = (in_sgn && md_src_b[MD_W-1]) ? (~md_src_b + 1'b1) : md_src_b;
  end

  muldiv_step #(.W(MD_W)) u_step (
    .is_div   (ctx.op[1]),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_step),
    .q_bit    (q_unused)
  );

  // Sign correction and divide-by-zero override applied in FIX.
  // The most negative dividend divided by -1 wraps naturally through the negate.
  always_comb begin
    prod = acc;
    if (ctx.op == MD_MULT && (ctx.sign_a ^ ctx.sign_b))
      prod = ~acc + 1'b1;
    quo = acc[MD_W-1:0];
    rem = acc[2*MD_W-1:MD_W];
    if (ctx.op == MD_DIV) begin
      if (ctx.sign_a ^ ctx.sign_b) quo = ~quo + 1'b1;
      if (ctx.sign_a)              rem = ~rem + 1'b1;
    end
    if (opnd == '0) begin
      quo = '1;
      rem = a_raw;
    end
    if (ctx.op[1]) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*MD_W-1:MD_W];
      res_lo = prod[MD_W-1:0];
    end
  end

  // FSM next-state and busy decode.
  always_comb begin
    state_nx = state;
    md_busy  = (state != MD_IDLE);
    case (state)
      MD_IDLE: if (md_start) state_nx = MD_RUN;
      MD_RUN:  if (cnt == CNT_W'(MD_ITER - 1)) state_nx = MD_FIX;
      MD_FIX:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_md) state <= MD_IDLE;
    else        state <= state_nx;
  end

  // Datapath: launch latches, iteration, result writeback and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst_md) begin
      cnt   <= '0;
      ctx   <= '0;
      a_raw <= '0;
      opnd  <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          // A same-cycle start overwrites these writes at completion.
          if (md_hi_write) hi <= md_src_a;
          if (md_lo_write) lo <= md_src_a;
          if (md_start) begin
            ctx.op     <= md_op_e'(md_op);
            ctx.sign_a <= in_sgn & md_src_a[MD_W-1];
            ctx.sign_b <= in_sgn & md_src_b[MD_W-1];
            a_raw      <= md_src_a;
            cnt        <= '0;
            if (md_op[1]) begin
              acc  <= {{MD_W{1'b0}}, abs_a};
              opnd <= abs_b;
            end else begin
              acc  <= {{MD_W{1'b0}}, abs_b};
              opnd <= abs_a;
            end
          end
        end
        MD_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        MD_FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random scoreboard bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_md;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_src_a, md_src_b;
  logic        md_hi_write, md_lo_write;
  logic        md_busy, md_done;
  logic [31:0] md_hi, md_lo;

  logic [63:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MD_W(32)) dut (
    .clk         (clk),
    .rst_md      (rst_md),
    .md_start    (md_start),
    .md_op       (md_op),
    .md_src_a    (md_src_a),
    .md_src_b    (md_src_b),
    .md_hi_write (md_hi_write),
    .md_lo_write (md_lo_write),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_hi       (md_hi),
    .md_lo       (md_lo)
  );

  // Reference result {HI, LO} from plain wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          q, r;
    longint unsigned uq, ur;
    logic [63:0]     res;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = 64'(ua * ub);
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic hw);
    md_start    = 1'b1;
    md_op       = op;
    md_src_a    = a;
    md_src_b    = b;
    md_hi_write = hw;
    md_lo_write = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    md_start    = 1'b0;
    md_hi_write = 1'b0;
    md_lo_write = 1'b0;
  endtask

  // Called in the first cycle after launch; returns in the md_done cycle.
  task automatic finish_op(input string tag, input int exp_busy);
    int n = 0;
    int guard = 0;
    logic [63:0] exp;
    while (!md_done && guard < 60) begin
      if (md_busy) n++;
      guard++;
      @(negedge clk);
    end
    chk({tag, " done"}, 64'(md_done), 64'd1);
    chk({tag, " busy_in_done"}, 64'(md_busy), 64'd0);
    chk({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    if (sb_q.size() == 0) chk({tag, " sb_empty"}, 64'(sb_q.size()), 64'd1);
    else begin
      exp = sb_q.pop_front();
      chk({tag, " hi"}, {32'd0, md_hi}, {32'd0, exp[63:32]});
      chk({tag, " lo"}, {32'd0, md_lo}, {32'd0, exp[31:0]});
    end
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    rst_md = 1'b1;
    md_start = 1'b0; md_op = 2'b00; md_src_a = '0; md_src_b = '0;
    md_hi_write = 1'b0; md_lo_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(md_busy), 64'd0);
    chk("rst done", 64'(md_done), 64'd0);
    chk("rst hi", {32'd0, md_hi}, 64'd0);
    chk("rst lo", {32'd0, md_lo}, 64'd0);
    rst_md = 1'b0;
    tick();

    // MULT -3 * 7
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    tick();
    finish_op("mult", 33);
    tick();
    chk("mult done_pulse", 64'(md_done), 64'd0);

    // MULTU max*max, then DIV -7/2 issued in the done cycle
    sb_q.push_back(64'hFFFF_FFFE_0000_0001);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    finish_op("multu", 33);
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    tick();
    chk("b2b accepted", 64'(md_busy), 64'd1);
    finish_op("div", 33);
    tick();

    // DIV overflow wraps
    sb_q.push_back(64'h0000_0000_8000_0000);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    tick();
    finish_op("div_ovf", 33);
    tick();

    // DIVU by zero
    sb_q.push_back(64'h0000_0064_FFFF_FFFF);
    issue(2'b11, 32'd100, 32'd0, 1'b0);
    tick();
    finish_op("divu0", 33);
    tick();

    // Random mix checked against the model
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (i == 5) rb = 32'd0;
      sb_q.push_back(model(rop, ra, rb));
      issue(rop, ra, rb, 1'b0);
      tick();
      finish_op($sformatf("rnd%0d op%0d", i, rop), 33);
      tick();
    end

    // DIVU 100/7 leaves HI=2, LO=14
    sb_q.push_back({32'd2, 32'd14});
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    tick();
    finish_op("divu", 33);
    tick();

    // MULT 5*5 with a start and MTHI pulse mid-run, both ignored
    sb_q.push_back(64'd25);
    issue(2'b00, 32'd5, 32'd5, 1'b0);
    tick();
    repeat (4) tick();
    issue(2'b11, 32'h0000_DEAD, 32'd3, 1'b1);
    tick();
    chk("ign hi_held", {32'd0, md_hi}, 64'd2);
    chk("ign lo_held", {32'd0, md_lo}, 64'd14);
    finish_op("ign", 28);
    tick();
    chk("ign no_restart", 64'(md_busy), 64'd0);

    // Reset mid-run aborts with no writeback
    issue(2'b00, 32'd5, 32'd5, 1'b0);
    tick();
    repeat (9) tick();
    rst_md = 1'b1;
    tick();
    rst_md = 1'b0;
    chk("abort busy", 64'(md_busy), 64'd0);
    chk("abort hi", {32'd0, md_hi}, 64'd0);
    chk("abort lo", {32'd0, md_lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) seen++;
    end
    chk("abort no_done", 64'(seen), 64'd0);

    // MTLO alone
    md_lo_write = 1'b1;
    md_src_a    = 32'h1234_5678;
    tick();
    chk("mtlo lo", {32'd0, md_lo}, 64'h1234_5678);
    chk("mtlo hi", {32'd0, md_hi}, 64'd0);
    chk("mtlo no_done", 64'(md_done), 64'd0);

    // MTHI together with MULTU 2*3
    sb_q.push_back(64'd6);
    issue(2'b01, 32'd2, 32'd3, 1'b1);
    tick();
    chk("mthi hi", {32'd0, md_hi}, 64'd2);
    chk("mthi lo", {32'd0, md_lo}, 64'h1234_5678);
    finish_op("mthi_multu", 33);
    tick();

    chk("sb drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
